// File: rtl/ps2_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_pkg
//  Description : Shared PS/2 Set-2 scancode constants, filter state encoding
//                and status-byte classification. Used by the scancode filter
//                and by the game reader FSM.
//  Revision    : 1.0  initial release
// ============================================================================
package ps2_pkg;

  // Scancode filter states
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_EXT    = 3'd1,
    S_BRK    = 3'd2,
    S_EXTBRK = 3'd3,
    S_PAUSE  = 3'd4
  } ps2_state_t;

  localparam logic [7:0] PS2_EXT        = 8'hE0;
  localparam logic [7:0] PS2_BRK        = 8'hF0;
  localparam logic [7:0] PS2_PAUSE      = 8'hE1;
  localparam logic [7:0] PS2_ENTER      = 8'h5A;

  // Fake-shift codes the keyboard wraps around some extended keys
  localparam logic [7:0] PS2_FAKE_SHIFT_L = 8'h12;
  localparam logic [7:0] PS2_FAKE_SHIFT_R = 8'h59;

  // Controller/keyboard status and handshake bytes, never key codes
  localparam int          PS2_NUM_STATUS = 8;
  localparam logic [7:0]  PS2_STATUS_BYTES [PS2_NUM_STATUS] =
    '{8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFD, 8'hFE, 8'hFF};

  // True when the byte is one of the status/handshake bytes
  function automatic logic is_status_byte(input logic [7:0] b);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < PS2_NUM_STATUS; i++) begin
      if (b == PS2_STATUS_BYTES[i]) hit = 1'b1;
    end
    return hit;
  endfunction

endpackage : ps2_pkg
`default_nettype wire

// File: rtl/key_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : key_fifo
//  Description : Parameterised first-word-fall-through FIFO. The head entry is
//                presented directly from storage; a push into a full FIFO is
//                accepted only when a pop happens in the same cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module key_fifo #(
  parameter int DEPTH = 4,   // power of 2, at least 2
  parameter int WIDTH = 9
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           push_data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           head_o,
  output logic                       valid_o,
  output logic                       full_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;

  logic w_full;
  logic w_empty;
  logic w_do_push;
  logic w_do_pop;

  assign w_full    = (count_q == CW'(DEPTH));
  assign w_empty   = (count_q == '0);
  assign w_do_pop  = pop_i && !w_empty;
  // A full FIFO can still take a write when the head leaves in the same cycle
  assign w_do_push = push_i && (!w_full || w_do_pop);

  // Storage, pointers and occupancy; pointers wrap naturally at DEPTH
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (w_do_push) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (w_do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign valid_o = !w_empty;
  assign full_o  = w_full;
  assign count_o = count_q;

endmodule : key_fifo
`default_nettype wire

// File: rtl/ps2_scancode_filter.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_scancode_filter
//  Description : Turns the raw PS/2 Set-2 byte stream into one make code per
//                physical keypress. Extended prefixes, break sequences, Pause
//                sequences, typematic repeats and status bytes are absorbed;
//                surviving make codes are queued in a FWFT key FIFO.
//  Revision    : 1.0  initial release
// ============================================================================
module ps2_scancode_filter
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int PAUSE_TAIL = 7
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [7:0]                    rx_data,
  input  logic                          rx_data_en,
  input  logic                          key_ready,
  output logic                          key_valid,
  output logic [7:0]                    key_code,
  output logic                          key_extended,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  output logic                          held_valid
);

  localparam int PCW = (PAUSE_TAIL > 1) ? $clog2(PAUSE_TAIL + 1) : 1;

  ps2_state_t       state_q;
  logic [7:0]       held_code_q;
  logic             held_ext_q;
  logic             held_valid_q;
  logic [PCW-1:0]   pause_cnt_q;
  logic             overflow_q;

  logic             w_make;
  logic             w_brk;
  logic             w_ext;
  logic             w_match;
  logic             w_push;
  logic             w_pop;
  logic             w_full;
  logic [8:0]       w_head;

  // Classify the current byte as a make or break event for the held-key logic
  always_comb begin
    w_make = 1'b0;
    w_brk  = 1'b0;
    w_ext  = 1'b0;
    if (rx_data_en) begin
      unique case (state_q)
        S_IDLE: begin
          if (rx_data != PS2_EXT && rx_data != PS2_BRK &&
              rx_data != PS2_PAUSE && !is_status_byte(rx_data)) begin
            w_make = 1'b1;
          end
        end
        S_EXT: begin
          w_ext = 1'b1;
          if (rx_data != PS2_BRK && rx_data != PS2_EXT &&
              rx_data != PS2_FAKE_SHIFT_L && rx_data != PS2_FAKE_SHIFT_R) begin
            w_make = 1'b1;
          end
        end
        S_BRK:    w_brk = 1'b1;
        S_EXTBRK: begin
          w_brk = 1'b1;
          w_ext = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Same key as the one still held means typematic repeat (make) or release (break)
  assign w_match = held_valid_q && (held_ext_q == w_ext) && (held_code_q == rx_data);
  assign w_push  = w_make && !w_match;
  assign w_pop   = key_valid && key_ready;

  // Protocol FSM, held-key tracker, pause counter and sticky overflow flag
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      held_code_q  <= 8'h00;
      held_ext_q   <= 1'b0;
      held_valid_q <= 1'b0;
      pause_cnt_q  <= '0;
      overflow_q   <= 1'b0;
    end else begin
      if (rx_data_en) begin
        unique case (state_q)
          S_IDLE: begin
            if (rx_data == PS2_EXT) begin
              state_q <= S_EXT;
            end else if (rx_data == PS2_BRK) begin
              state_q <= S_BRK;
            end else if (rx_data == PS2_PAUSE) begin
              state_q     <= S_PAUSE;
              pause_cnt_q <= PCW'(PAUSE_TAIL);
            end
          end
          S_EXT: begin
            if (rx_data == PS2_BRK) begin
              state_q <= S_EXTBRK;
            end else if (rx_data != PS2_EXT) begin
              state_q <= S_IDLE;
            end
          end
          S_BRK, S_EXTBRK: state_q <= S_IDLE;
          S_PAUSE: begin
            if (pause_cnt_q <= PCW'(1)) begin
              pause_cnt_q <= '0;
              state_q     <= S_IDLE;
            end else begin
              pause_cnt_q <= pause_cnt_q - 1'b1;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end

      // The held key follows every new press, even when the FIFO drops it
      if (w_push) begin
        held_code_q  <= rx_data;
        held_ext_q   <= w_ext;
        held_valid_q <= 1'b1;
      end else if (w_brk && w_match) begin
        held_valid_q <= 1'b0;
      end

      if (w_push && w_full && !w_pop) overflow_q <= 1'b1;
    end
  end

  key_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (9)
  ) u_key_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (w_push),
    .push_data_i ({w_ext, rx_data}),
    .pop_i       (w_pop),
    .head_o      (w_head),
    .valid_o     (key_valid),
    .full_o      (w_full),
    .count_o     (fifo_count)
  );

  assign key_code     = w_head[7:0];
  assign key_extended = w_head[8];
  assign overflow     = overflow_q;
  assign held_valid   = held_valid_q;

endmodule : ps2_scancode_filter
`default_nettype wire

// File: tb/tb_ps2_scancode_filter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ps2_scancode_filter
//  Description : Directed self-checking bench for ps2_scancode_filter.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ps2_scancode_filter;
  import ps2_pkg::*;

  localparam int FIFO_DEPTH = 4;
  localparam int PAUSE_TAIL = 7;

  logic       clk;
  logic       reset;
  logic [7:0] rx_data;
  logic       rx_data_en;
  logic       key_ready;
  logic       key_valid;
  logic [7:0] key_code;
  logic       key_extended;
  logic [2:0] fifo_count;
  logic       overflow;
  logic       held_valid;

  int n_total;
  int n_bad;

  ps2_scancode_filter #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .PAUSE_TAIL (PAUSE_TAIL)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .rx_data      (rx_data),
    .rx_data_en   (rx_data_en),
    .key_ready    (key_ready),
    .key_valid    (key_valid),
    .key_code     (key_code),
    .key_extended (key_extended),
    .fifo_count   (fifo_count),
    .overflow     (overflow),
    .held_valid   (held_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One strobed byte; returns on the following falling edge
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data    = b;
    rx_data_en = 1'b1;
    @(negedge clk);
    rx_data_en = 1'b0;
  endtask

  task automatic send_seq(input logic [7:0] seq[$]);
    foreach (seq[i]) send_byte(seq[i]);
  endtask

  // Check the head entry, then pop it
  task automatic pop_expect(input string tag, input logic [7:0] code, input logic ext);
    @(negedge clk);
    check_val({tag, "_valid"}, 32'(key_valid), 32'd1);
    check_val({tag, "_code"},  32'(key_code),  32'(code));
    check_val({tag, "_ext"},   32'(key_extended), 32'(ext));
    key_ready = 1'b1;
    @(negedge clk);
    key_ready = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    check_val({tag, "_valid"}, 32'(key_valid),    32'd0);
    check_val({tag, "_code"},  32'(key_code),     32'd0);
    check_val({tag, "_ext"},   32'(key_extended), 32'd0);
    check_val({tag, "_count"}, 32'(fifo_count),   32'd0);
    check_val({tag, "_ovf"},   32'(overflow),     32'd0);
    check_val({tag, "_held"},  32'(held_valid),   32'd0);
  endtask

  initial begin
    n_total    = 0;
    n_bad      = 0;
    reset      = 1'b1;
    rx_data    = 8'h00;
    rx_data_en = 1'b0;
    key_ready  = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check_zero("rst");

    // Press/release A
    send_byte(8'h1C);
    check_val("a_held_on", 32'(held_valid), 32'd1);
    send_seq('{8'hF0, 8'h1C});
    check_val("a_held_off", 32'(held_valid), 32'd0);
    check_val("a_count", 32'(fifo_count), 32'd1);
    pop_expect("a_pop", 8'h1C, 1'b0);
    check_val("a_empty", 32'(key_valid), 32'd0);

    // Typematic repeat, release, press again
    send_seq('{8'h1C, 8'h1C, 8'h1C, 8'h1C});
    check_val("typ_count1", 32'(fifo_count), 32'd1);
    send_seq('{8'hF0, 8'h1C, 8'h1C});
    check_val("typ_count2", 32'(fifo_count), 32'd2);
    pop_expect("typ_pop0", 8'h1C, 1'b0);
    pop_expect("typ_pop1", 8'h1C, 1'b0);

    // Extended up arrow, then a fake shift
    send_seq('{8'hE0, 8'h75, 8'hE0, 8'hF0, 8'h75, 8'hE0, 8'h12});
    check_val("ext_count", 32'(fifo_count), 32'd1);
    check_val("ext_held", 32'(held_valid), 32'd0);
    pop_expect("ext_pop", 8'h75, 1'b1);

    // Status bytes and a Pause sequence
    send_seq('{8'hAA, 8'hFA, 8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77});
    check_val("pause_count", 32'(fifo_count), 32'd0);
    check_val("pause_state", 32'(dut.state_q), 32'(S_IDLE));
    send_byte(PS2_ENTER);
    check_val("pause_count5a", 32'(fifo_count), 32'd1);
    pop_expect("pause_pop", 8'h5A, 1'b0);

    // Overflow with the consumer stalled
    send_seq('{8'h16, 8'hF0, 8'h16, 8'h1E, 8'hF0, 8'h1E, 8'h26, 8'hF0, 8'h26,
               8'h25, 8'hF0, 8'h25, 8'h2E, 8'hF0, 8'h2E});
    check_val("ovf_count", 32'(fifo_count), 32'd4);
    check_val("ovf_flag", 32'(overflow), 32'd1);
    check_val("ovf_head", 32'(key_code), 32'h16);
    pop_expect("ovf_pop0", 8'h16, 1'b0);
    pop_expect("ovf_pop1", 8'h1E, 1'b0);
    pop_expect("ovf_pop2", 8'h26, 1'b0);
    pop_expect("ovf_pop3", 8'h25, 1'b0);
    check_val("ovf_drained", 32'(key_valid), 32'd0);
    check_val("ovf_sticky", 32'(overflow), 32'd1);

    // Full FIFO: push and pop in the same cycle
    do_reset();
    check_val("rst2_ovf", 32'(overflow), 32'd0);
    send_seq('{8'h16, 8'h1E, 8'h26, 8'h25});
    check_val("full_count", 32'(fifo_count), 32'd4);
    @(negedge clk);
    rx_data    = 8'h2E;
    rx_data_en = 1'b1;
    key_ready  = 1'b1;
    @(negedge clk);
    rx_data_en = 1'b0;
    key_ready  = 1'b0;
    check_val("pp_count", 32'(fifo_count), 32'd4);
    check_val("pp_ovf", 32'(overflow), 32'd0);
    check_val("pp_head", 32'(key_code), 32'h1E);

    // Reset in the middle of an extended sequence
    send_byte(PS2_EXT);
    do_reset();
    check_zero("rst3");
    send_byte(8'h75);
    check_val("post_count", 32'(fifo_count), 32'd1);
    check_val("post_code", 32'(key_code), 32'h75);
    check_val("post_ext", 32'(key_extended), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  // Safety bound so the bench always ends
  initial begin
    #200000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule : tb_ps2_scancode_filter
`default_nettype wire
